// File: rtl/jimmy_core.sv
// jimmy_core: 8-bit, four-register teaching CPU.
// The core fetches from a synchronous program ROM. It reads input port 0 and
// drives output port 1, with a one-cycle write strobe for each output port.
// Sequence: FETCH -> DECODE (single-byte ops run here) -> FETCH2 -> EXEC2 (two-byte ops).
module jimmy_core #(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic       jimmy_clk,
    input  logic       reset,
    input  logic [7:0] in_port_0,
    output logic [7:0] out_port_1,
    output logic [3:0] out_strobe,
    input  logic [7:0] inst_data_bus,
    output logic [7:0] inst_address_bus
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_FETCH2 = 3'd2;
    localparam logic [2:0] ST_EXEC2  = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_JNC  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0] state;
    logic [7:0] pc;
    // Only opcode and rd are needed once the instruction reaches EXEC2.
    logic [7:2] ir;
    logic [7:0] regs [4];
    logic       z_flag;
    logic       c_flag;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] rd_val;
    logic [7:0] rs_val;
    logic [8:0] alu_out;
    logic       two_byte;
    logic       taken;
    logic [7:0] pc_inc;

    // ALU: bit 8 is the carry for ADD and the borrow for SUB. It is zero for logic ops.
    function automatic logic [8:0] alu(input logic [3:0] f, input logic [7:0] a,
                                       input logic [7:0] b);
        case (f)
            OP_ADD:  alu = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu = {1'b0, a} - {1'b0, b};
            OP_AND:  alu = {1'b0, a & b};
            OP_OR:   alu = {1'b0, a | b};
            OP_XOR:  alu = {1'b0, a ^ b};
            default: alu = {1'b0, a};
        endcase
    endfunction

    assign inst_address_bus = pc;

    // Decode the byte currently on the ROM bus, and evaluate the branch condition held in IR.
    always_comb begin
        op       = inst_data_bus[7:4];
        rd       = inst_data_bus[3:2];
        rs       = inst_data_bus[1:0];
        rd_val   = regs[rd];
        rs_val   = regs[rs];
        alu_out  = alu(op, rd_val, rs_val);
        two_byte = (op == OP_LDI) || ((op >= OP_JMP) && (op <= OP_JNC));
        pc_inc   = pc + 8'd1;
        case (ir[7:4])
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = z_flag;
            OP_JNZ:  taken = ~z_flag;
            OP_JC:   taken = c_flag;
            OP_JNC:  taken = ~c_flag;
            default: taken = 1'b0;
        endcase
    end

    // Sequencer, register file, flags and output port. Reset wins over any instruction in progress.
    always_ff @(posedge jimmy_clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_VECTOR;
            ir         <= '0;
            z_flag     <= 1'b0;
            c_flag     <= 1'b0;
            out_port_1 <= 8'h00;
            out_strobe <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            // Strobes last one cycle unless an OUT re-arms them in DECODE.
            out_strobe <= 4'b0000;
            case (state)
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir <= inst_data_bus[7:2];
                    if (op == OP_HALT) begin
                        // PC stays on the HALT byte, so the address bus freezes there.
                        state <= ST_HALT;
                    end else begin
                        pc    <= pc_inc;
                        state <= two_byte ? ST_FETCH2 : ST_FETCH;
                        case (op)
                            OP_MOV: regs[rd] <= rs_val;
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                regs[rd] <= alu_out[7:0];
                                z_flag   <= (alu_out[7:0] == 8'h00);
                                c_flag   <= alu_out[8];
                            end
                            OP_IN:  regs[rd] <= (rs == 2'd0) ? in_port_0 : 8'h00;
                            OP_OUT: begin
                                out_strobe <= 4'b0001 << rd;
                                if (rd == 2'd1) begin
                                    out_port_1 <= rs_val;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_FETCH2: begin
                    state <= ST_EXEC2;
                end
                ST_EXEC2: begin
                    state <= ST_FETCH;
                    if (ir[7:4] == OP_LDI) begin
                        regs[ir[3:2]] <= inst_data_bus;
                        pc            <= pc_inc;
                    end else begin
                        pc <= taken ? inst_data_bus : pc_inc;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jimmy_core.sv
// tb_jimmy_core: directed programs run on jimmy_core from a bench-side synchronous ROM.
module tb_jimmy_core;

    logic       jimmy_clk;
    logic       reset;
    logic [7:0] in_port_0;
    logic [7:0] out_port_1;
    logic [3:0] out_strobe;
    logic [7:0] inst_data_bus;
    logic [7:0] inst_address_bus;

    logic [7:0] rom [256];
    logic [7:0] pq [$];

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the negedge monitor)
    logic       mon_en = 1'b0;
    int         mon_cyc = 0;
    int         last_chg = 0;
    int         wide = 0;
    logic [7:0] falls = 8'h00;
    logic [3:0] prev_st = 4'b0000;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] val_q [$];
    logic [3:0] st_q [$];
    int         cyc_q [$];

    jimmy_core #(.RESET_VECTOR(8'h00)) dut (
        .jimmy_clk        (jimmy_clk),
        .reset            (reset),
        .in_port_0        (in_port_0),
        .out_port_1       (out_port_1),
        .out_strobe       (out_strobe),
        .inst_data_bus    (inst_data_bus),
        .inst_address_bus (inst_address_bus)
    );

    initial jimmy_clk = 1'b0;
    always #5 jimmy_clk = ~jimmy_clk;

    // Registered ROM read: data follows the address one edge later
    always @(posedge jimmy_clk) inst_data_bus <= rom[inst_address_bus];

    // Input port counts strobe[1] falling edges
    assign in_port_0 = falls;

    // Record strobe pulses, pulse widths and address activity
    always @(negedge jimmy_clk) begin
        mon_cyc = mon_cyc + 1;
        if (!mon_en) begin
            val_q.delete();
            st_q.delete();
            cyc_q.delete();
            wide      = 0;
            falls     = 8'h00;
            prev_st   = 4'b0000;
            prev_addr = inst_address_bus;
            last_chg  = mon_cyc;
        end else begin
            if (out_strobe != 4'b0000) begin
                val_q.push_back(out_port_1);
                st_q.push_back(out_strobe);
                cyc_q.push_back(mon_cyc);
                if (prev_st != 4'b0000) wide = wide + 1;
            end
            if (prev_st[1] && !out_strobe[1]) falls = falls + 8'd1;
            if (inst_address_bus != prev_addr) last_chg = mon_cyc;
            prev_addr = inst_address_bus;
            prev_st   = out_strobe;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge jimmy_clk);
            #2;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < pq.size(); i++) rom[i] = pq[i];
    endtask

    // Reset for two edges, then release; returns during the first FETCH cycle
    task automatic start();
        mon_en = 1'b0;
        reset  = 1'b1;
        step(2);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic check_strobes_port1(input string tag);
        int bad;
        bad = 0;
        foreach (st_q[i]) if (st_q[i] != 4'b0010) bad++;
        check({tag, "_only_port1"}, bad, 0);
        check({tag, "_one_cycle"}, wide, 0);
    endtask

    logic [7:0] fib_exp [13] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144};

    initial begin
        int         bad;
        logic [7:0] prev;
        reset = 1'b1;
        pq = {};
        load_prog();

        // Reset hold
        step(3);
        check("rst_addr", inst_address_bus, 8'h00);
        check("rst_out", out_port_1, 8'h00);
        check("rst_strobe", out_strobe, 4'b0000);

        // Fibonacci
        pq = {8'h70, 8'h00, 8'h74, 8'h01, 8'h94, 8'h19, 8'h24, 8'h12, 8'hE0, 8'h04, 8'hF0};
        load_prog();
        start();
        check("rel_addr_fetch", inst_address_bus, 8'h00);
        step(1);
        check("rel_addr_decode", inst_address_bus, 8'h00);
        step(1);
        check("rel_addr_next", inst_address_bus, 8'h01);
        step(400);
        check("fib_count", val_q.size(), 13);
        if (val_q.size() == 13)
            for (int i = 0; i < 13; i++) check($sformatf("fib_val%0d", i), val_q[i], fib_exp[i]);
        check_strobes_port1("fib");
        check("fib_halt_addr", inst_address_bus, 8'h0A);
        check("fib_halt_stable", (mon_cyc - last_chg) > 100, 1);

        // Reset clears the output register
        mon_en = 1'b0;
        reset  = 1'b1;
        step(1);
        check("rst2_out", out_port_1, 8'h00);
        check("rst2_addr", inst_address_bus, 8'h00);
        check("rst2_strobe", out_strobe, 4'b0000);

        // IN/OUT loop: strobe every 8 cycles, value follows the input counter
        pq = {8'h80, 8'h94, 8'hA0, 8'h00};
        load_prog();
        start();
        step(60);
        check("io_count_ge6", val_q.size() >= 6, 1);
        if (val_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("io_val%0d", i), val_q[i], i);
            for (int i = 1; i < 6; i++)
                check($sformatf("io_period%0d", i), cyc_q[i] - cyc_q[i-1], 8);
        end
        check_strobes_port1("io");

        // Flags: FF+01 -> Z=1,C=1; 00-01 -> FF, C=1, Z=0; JNC falls through
        pq = {8'h70, 8'hFF, 8'h74, 8'h01, 8'h21, 8'hB0, 8'h09, 8'h9C, 8'hF0,
              8'hD0, 8'h0D, 8'h9C, 8'hF0, 8'h31, 8'hE0, 8'h12, 8'h94, 8'hF0,
              8'h9C, 8'hF0};
        load_prog();
        start();
        step(60);
        check("flag_count", val_q.size(), 1);
        if (val_q.size() == 1) check("flag_sub_val", val_q[0], 8'hFF);
        check_strobes_port1("flag");
        check("flag_halt_addr", inst_address_bus, 8'h11);

        // Logic ops clear C and set Z on a zero result
        pq = {8'h7C, 8'hFF, 8'h2F, 8'h70, 8'h0F, 8'h74, 8'hF0, 8'h51, 8'h94,
              8'h41, 8'h94, 8'h61, 8'h94, 8'hB0, 8'h11, 8'h9C, 8'hF0, 8'hD0,
              8'h0F, 8'hF0};
        load_prog();
        start();
        step(80);
        check("logic_count", val_q.size(), 3);
        if (val_q.size() == 3) begin
            check("logic_or", val_q[0], 8'hFF);
            check("logic_and", val_q[1], 8'hF0);
            check("logic_xor", val_q[2], 8'h00);
        end
        check_strobes_port1("logic");
        check("logic_halt_addr", inst_address_bus, 8'h13);

        // Reset during EXEC2 of a JMP
        pq = {8'h70, 8'h33, 8'h94, 8'hA0, 8'h40};
        load_prog();
        rom[8'h40] = 8'hF0;
        start();
        step(9);
        check("jr_pre_addr", inst_address_bus, 8'h04);
        check("jr_pre_out", out_port_1, 8'h33);
        mon_en = 1'b0;
        reset  = 1'b1;
        step(1);
        check("jr_addr", inst_address_bus, 8'h00);
        check("jr_out", out_port_1, 8'h00);
        check("jr_strobe", out_strobe, 4'b0000);
        rom[0] = 8'h94;
        rom[1] = 8'hF0;
        reset  = 1'b0;
        mon_en = 1'b1;
        step(12);
        check("jr_count", val_q.size(), 1);
        if (val_q.size() == 1) check("jr_r0_cleared", val_q[0], 8'h00);
        check("jr_halt_addr", inst_address_bus, 8'h01);

        // PC wrap over a NOP-filled ROM
        pq = {};
        load_prog();
        start();
        bad  = 0;
        prev = 8'h00;
        for (int i = 1; i < 512; i++) begin
            step(1);
            if (inst_address_bus != prev) begin
                if (inst_address_bus != prev + 8'd1) bad++;
                prev = inst_address_bus;
            end
        end
        check("wrap_addr_ff", inst_address_bus, 8'hFF);
        step(1);
        check("wrap_addr_00", inst_address_bus, 8'h00);
        check("wrap_monotonic", bad, 0);
        check("wrap_no_strobe", st_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
